// File: rtl/accum_sched_if.sv
// Requester-side bus of the shared accumulator: per-requester request/value
// lanes in, one-hot grant and the per-burst result strobe out.
interface accum_sched_if #(
  parameter int NREQ  = 4,
  parameter int SUM_W = 8
);
  logic [NREQ-1:0]         req;
  logic [NREQ-1:0]         in_valid;
  logic [NREQ-1:0]         in_term;
  logic [4*NREQ-1:0]       in_value;
  logic [NREQ-1:0]         gnt;
  logic [SUM_W-1:0]        o_sum;
  logic [$clog2(NREQ)-1:0] o_id;
  logic                    o_done;
  logic                    o_sat;
  logic                    o_tmo;

  modport master (
    output req, in_valid, in_term, in_value,
    input  gnt, o_sum, o_id, o_done, o_sat, o_tmo
  );

  modport slave (
    input  req, in_valid, in_term, in_value,
    output gnt, o_sum, o_id, o_done, o_sat, o_tmo
  );
endinterface

// File: rtl/accum_sched.sv
// Round-robin shared accumulator: grants one requester a burst, sums its
// 4-bit values with saturation, and ends the burst on term or idle timeout.
module accum_sched #(
  parameter int NREQ  = 4,
  parameter int SUM_W = 8,
  parameter int TMO   = 15
) (
  input  logic          clk,
  input  logic          rstn,
  accum_sched_if.slave  bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(TMO + 1);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   win_q, win_d;
  logic [IDW-1:0]   o_id_q, o_id_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [SUM_W-1:0] o_sum_q, o_sum_d;
  logic             sat_q, sat_d;
  logic             tmo_q, tmo_d;
  logic [CW-1:0]    idle_q, idle_d;

  logic             found;
  logic [IDW-1:0]   pick;
  logic             beat;
  logic             term;
  logic [3:0]       val;
  logic [SUM_W:0]   add;
  logic [CW-1:0]    idle_inc;

  // Returns {overflow, clamped sum}.
  function automatic logic [SUM_W:0] sat_add(input logic [SUM_W-1:0] a,
                                             input logic [3:0] b);
    logic [SUM_W:0] s;
    s = {1'b0, a} + (SUM_W+1)'(b);
    if (s[SUM_W]) return {1'b1, {SUM_W{1'b1}}};
    return s;
  endfunction

  // First requester at or after ptr, wrapping.
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = ptr_q;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = IDW'(idx);
      end
    end
  end

  assign beat     = bus.in_valid[win_q];
  assign term     = bus.in_term[win_q];
  assign val      = bus.in_value[int'(win_q)*4 +: 4];
  assign add      = sat_add(sum_q, val);
  assign idle_inc = idle_q + CW'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    sum_d   = sum_q;
    sat_d   = sat_q;
    tmo_d   = tmo_q;
    idle_d  = idle_q;
    o_sum_d = o_sum_q;
    o_id_d  = o_id_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          win_d   = pick;
          sum_d   = '0;
          sat_d   = 1'b0;
          tmo_d   = 1'b0;
          idle_d  = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        if (beat) begin
          sum_d  = add[SUM_W-1:0];
          sat_d  = sat_q | add[SUM_W];
          idle_d = '0;
        end else if (!term) begin
          idle_d = idle_inc;
        end
        // A beat landing with term is folded into the result.
        if (term) begin
          state_d = DONE;
          o_sum_d = beat ? add[SUM_W-1:0] : sum_q;
          o_id_d  = win_q;
        end else if (!beat && idle_inc == CW'(TMO)) begin
          state_d = DONE;
          tmo_d   = 1'b1;
          o_sum_d = sum_q;
          o_id_d  = win_q;
        end
      end
      DONE: begin
        ptr_d   = (win_q == IDW'(NREQ - 1)) ? '0 : win_q + IDW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      sum_q   <= '0;
      sat_q   <= 1'b0;
      tmo_q   <= 1'b0;
      idle_q  <= '0;
      o_sum_q <= '0;
      o_id_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      sum_q   <= sum_d;
      sat_q   <= sat_d;
      tmo_q   <= tmo_d;
      idle_q  <= idle_d;
      o_sum_q <= o_sum_d;
      o_id_q  <= o_id_d;
    end
  end

  assign bus.gnt    = (state_q == ACC) ? (NREQ'(1) << win_q) : '0;
  assign bus.o_done = (state_q == DONE);
  assign bus.o_sat  = (state_q == DONE) && sat_q;
  assign bus.o_tmo  = (state_q == DONE) && tmo_q;
  assign bus.o_sum  = o_sum_q;
  assign bus.o_id   = o_id_q;
endmodule
